// File: rtl/otter_cache_pkg.sv
// ============================================================================
// Package     : otter_cache_pkg
// Description : Shared types and width helpers for the cacheline adaptors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package otter_cache_pkg;

   // Burst engine states
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_BURST = 2'd1,
      WR_BURST = 2'd2,
      RESP     = 2'd3
   } adaptor_state_t;

   // Beats per line; 0 flags a line width that is not a whole number of beats
   function automatic int BEATS_OF(input int line_w, input int beat_w);
      if (beat_w <= 0 || (line_w % beat_w) != 0) begin
         return 0;
      end
      return line_w / beat_w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/line_beat_buffer.sv
// ============================================================================
// Module      : line_beat_buffer
// Description : Line-wide data/mask register with parallel load, indexed
//               beat write and indexed beat read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_beat_buffer
   import otter_cache_pkg::*;
#(
   parameter int  LINE_W = 256,
   parameter int  BEAT_W = 32,
   localparam int BEATS  = BEATS_OF(LINE_W, BEAT_W),
   localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load_i,
   input  logic [LINE_W-1:0]   line_i,
   input  logic [LINE_W/8-1:0] mask_i,
   input  logic                beat_we_i,
   input  logic [IDX_W-1:0]    beat_idx_i,
   input  logic [BEAT_W-1:0]   beat_wdata_i,
   output logic [BEAT_W-1:0]   beat_rdata_o,
   output logic [BEAT_W/8-1:0] beat_mask_o,
   output logic [LINE_W-1:0]   line_merged_o
);

   logic [LINE_W-1:0]   line_q;
   logic [LINE_W/8-1:0] mask_q;

   // Current line with the incoming beat spliced in at the selected index
   always_comb begin
      line_merged_o = line_q;
      line_merged_o[int'(beat_idx_i) * BEAT_W +: BEAT_W] = beat_wdata_i;
   end

   // Line/mask storage: whole-line load wins over a single beat write
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         line_q <= '0;
         mask_q <= '0;
      end else if (load_i) begin
         line_q <= line_i;
         mask_q <= mask_i;
      end else if (beat_we_i) begin
         line_q <= line_merged_o;
      end
   end

   assign beat_rdata_o = line_q[int'(beat_idx_i) * BEAT_W +: BEAT_W];
   assign beat_mask_o  = mask_q[int'(beat_idx_i) * (BEAT_W / 8) +: (BEAT_W / 8)];

endmodule

`default_nettype wire

// File: rtl/burst_line_adaptor.sv
// ============================================================================
// Module      : burst_line_adaptor
// Description : Converts line-wide cache read/writeback requests into
//               ascending-address memory bursts of BEAT_W-wide beats.
//               Reset is asserted asynchronously; its release is expected to
//               be synchronised to clk upstream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module burst_line_adaptor
   import otter_cache_pkg::*;
#(
   parameter int LINE_W = 256,
   parameter int BEAT_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ca_read,
   input  logic                ca_write,
   input  logic [ADDR_W-1:0]   ca_address,
   input  logic [LINE_W-1:0]   ca_wdata,
   input  logic [LINE_W/8-1:0] ca_byte_enable,
   output logic [LINE_W-1:0]   ca_rdata,
   output logic                ca_resp,
   output logic                pmem_read,
   output logic                pmem_write,
   output logic [ADDR_W-1:0]   pmem_address,
   output logic [BEAT_W-1:0]   pmem_wdata,
   output logic [BEAT_W/8-1:0] pmem_byte_enable,
   input  logic [BEAT_W-1:0]   pmem_rdata,
   input  logic                pmem_resp
);

   localparam int                BEATS      = BEATS_OF(LINE_W, BEAT_W);
   localparam int                IDX_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int                BEAT_SHIFT = $clog2(BEAT_W / 8);
   localparam logic [ADDR_W-1:0] LINE_MASK  = ADDR_W'(LINE_W / 8 - 1);
   localparam logic [IDX_W-1:0]  LAST_BEAT  = IDX_W'(BEATS - 1);

   adaptor_state_t      state_q;
   logic [IDX_W-1:0]    beat_cnt_q;
   logic [ADDR_W-1:0]   base_q;
   logic [LINE_W-1:0]   ca_rdata_q;
   logic                ca_resp_q;
   logic                pmem_read_q;
   logic                pmem_write_q;

   logic [ADDR_W-1:0]   line_addr;
   logic                wr_accept;
   logic                rd_beat;
   logic [BEAT_W-1:0]   buf_beat;
   logic [BEAT_W/8-1:0] buf_mask;
   logic [LINE_W-1:0]   line_merged;

   assign line_addr = ca_address & ~LINE_MASK;
   assign wr_accept = (state_q == IDLE) && ca_write;
   assign rd_beat   = (state_q == RD_BURST) && pmem_resp;

   // The same buffer holds the writeback line or the line being assembled
   line_beat_buffer #(
      .LINE_W(LINE_W),
      .BEAT_W(BEAT_W)
   ) u_buf (
      .clk          (clk),
      .rst          (rst),
      .load_i       (wr_accept),
      .line_i       (ca_wdata),
      .mask_i       (ca_byte_enable),
      .beat_we_i    (rd_beat),
      .beat_idx_i   (beat_cnt_q),
      .beat_wdata_i (pmem_rdata),
      .beat_rdata_o (buf_beat),
      .beat_mask_o  (buf_mask),
      .line_merged_o(line_merged)
   );

   // Burst FSM: write has priority, one beat per pmem_resp, single-cycle ca_resp
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         beat_cnt_q   <= '0;
         base_q       <= '0;
         ca_rdata_q   <= '0;
         ca_resp_q    <= 1'b0;
         pmem_read_q  <= 1'b0;
         pmem_write_q <= 1'b0;
      end else begin
         ca_resp_q <= 1'b0;
         case (state_q)
            IDLE: begin
               beat_cnt_q <= '0;
               if (ca_write) begin
                  base_q       <= line_addr;
                  pmem_write_q <= 1'b1;
                  state_q      <= WR_BURST;
               end else if (ca_read) begin
                  base_q      <= line_addr;
                  pmem_read_q <= 1'b1;
                  state_q     <= RD_BURST;
               end
            end
            RD_BURST: begin
               if (pmem_resp) begin
                  if (beat_cnt_q == LAST_BEAT) begin
                     beat_cnt_q  <= '0;
                     ca_rdata_q  <= line_merged;
                     ca_resp_q   <= 1'b1;
                     pmem_read_q <= 1'b0;
                     state_q     <= RESP;
                  end else begin
                     beat_cnt_q <= beat_cnt_q + 1'b1;
                  end
               end
            end
            WR_BURST: begin
               if (pmem_resp) begin
                  if (beat_cnt_q == LAST_BEAT) begin
                     beat_cnt_q   <= '0;
                     ca_resp_q    <= 1'b1;
                     pmem_write_q <= 1'b0;
                     state_q      <= RESP;
                  end else begin
                     beat_cnt_q <= beat_cnt_q + 1'b1;
                  end
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ca_rdata         = ca_rdata_q;
   assign ca_resp          = ca_resp_q;
   assign pmem_read        = pmem_read_q;
   assign pmem_write       = pmem_write_q;
   // Address and write beat are only driven while a burst is in flight
   assign pmem_address     = (pmem_read_q || pmem_write_q) ?
                             (base_q + (ADDR_W'(beat_cnt_q) << BEAT_SHIFT)) : '0;
   assign pmem_wdata       = pmem_write_q ? buf_beat : '0;
   assign pmem_byte_enable = pmem_write_q ? buf_mask : '0;

endmodule

`default_nettype wire

// File: tb/tb_burst_line_adaptor.sv
// ============================================================================
// Module      : tb_burst_line_adaptor
// Description : Self-checking bench for burst_line_adaptor (256/32 and 512/64)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_burst_line_adaptor;

   localparam int NB = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // 256/32 instance
   logic         ca_read, ca_write, ca_resp;
   logic [31:0]  ca_address, ca_byte_enable;
   logic [255:0] ca_wdata, ca_rdata;
   logic         pmem_read, pmem_write, pmem_resp;
   logic [31:0]  pmem_address, pmem_wdata, pmem_rdata;
   logic [3:0]   pmem_byte_enable;

   // 512/64 instance
   logic         b_ca_read, b_ca_write, b_ca_resp;
   logic [31:0]  b_ca_address;
   logic [63:0]  b_ca_byte_enable;
   logic [511:0] b_ca_wdata, b_ca_rdata;
   logic         b_pmem_read, b_pmem_write, b_pmem_resp;
   logic [31:0]  b_pmem_address;
   logic [63:0]  b_pmem_wdata, b_pmem_rdata;
   logic [7:0]   b_pmem_byte_enable;

   burst_line_adaptor #(.LINE_W(256), .BEAT_W(32), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .ca_read(ca_read), .ca_write(ca_write),
      .ca_address(ca_address), .ca_wdata(ca_wdata), .ca_byte_enable(ca_byte_enable),
      .ca_rdata(ca_rdata), .ca_resp(ca_resp), .pmem_read(pmem_read),
      .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
      .pmem_byte_enable(pmem_byte_enable), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp));

   burst_line_adaptor #(.LINE_W(512), .BEAT_W(64), .ADDR_W(32)) dut_b (
      .clk(clk), .rst(rst), .ca_read(b_ca_read), .ca_write(b_ca_write),
      .ca_address(b_ca_address), .ca_wdata(b_ca_wdata), .ca_byte_enable(b_ca_byte_enable),
      .ca_rdata(b_ca_rdata), .ca_resp(b_ca_resp), .pmem_read(b_pmem_read),
      .pmem_write(b_pmem_write), .pmem_address(b_pmem_address), .pmem_wdata(b_pmem_wdata),
      .pmem_byte_enable(b_pmem_byte_enable), .pmem_rdata(b_pmem_rdata), .pmem_resp(b_pmem_resp));

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
   endtask

   // Bus-side memories (written by beats) and transaction-level reference memories
   logic [7:0] bmem [0:1023];
   logic [7:0] refm [0:1023];
   logic [7:0] bmemB[0:1023];
   logic [7:0] refB [0:1023];

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [63:0] data;
      logic [7:0]  be;
   } beat_t;
   beat_t logA[$];
   beat_t logB[$];

   int   per = 1;
   bit   rnd_resp = 1'b0;
   int   strobesA = 0;
   int   last_strobeA = 0;
   logic pvA = 1'b0, prA = 1'b0;
   logic [31:0] paA, pwA;
   logic [3:0]  pbA;
   logic [255:0] last_rd = '0;

   // Memory responder for the 256/32 instance, with stalls and spurious idle strobes
   initial begin
      int  ctr;
      bit  give;
      int  a;
      ctr = 0;
      pmem_resp = 1'b0;
      pmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (pmem_read || pmem_write) begin
            if (pvA && !prA) begin
               chk("hold_addr", pmem_address, paA);
               chk("hold_wdata", pmem_wdata, pwA);
               chk("hold_be", pmem_byte_enable, pbA);
            end
            give = rnd_resp ? ($urandom_range(0, 1) == 1) : (ctr == per - 1);
            ctr  = give ? 0 : ctr + 1;
            a    = int'(pmem_address[9:0]);
            if (give) begin
               if (pmem_write)
                  for (int j = 0; j < 4; j++)
                     if (pmem_byte_enable[j]) bmem[a + j] = pmem_wdata[8*j +: 8];
               pmem_rdata = {bmem[a + 3], bmem[a + 2], bmem[a + 1], bmem[a]};
               logA.push_back('{pmem_write, pmem_address, 64'(pmem_wdata), 8'(pmem_byte_enable)});
               strobesA++;
               last_strobeA = cyc;
            end else begin
               pmem_rdata = $urandom;
            end
            pmem_resp = give;
            pvA = 1'b1;
            prA = give;
            paA = pmem_address;
            pwA = pmem_wdata;
            pbA = pmem_byte_enable;
         end else begin
            ctr = 0;
            pvA = 1'b0;
            pmem_resp = !ca_resp && ($urandom_range(0, 3) == 0);
            pmem_rdata = $urandom;
         end
      end
   end

   // Memory responder for the 512/64 instance, zero-wait
   initial begin
      int a;
      b_pmem_resp = 1'b0;
      b_pmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (b_pmem_read || b_pmem_write) begin
            a = int'(b_pmem_address[9:0]);
            if (b_pmem_write)
               for (int j = 0; j < 8; j++)
                  if (b_pmem_byte_enable[j]) bmemB[a + j] = b_pmem_wdata[8*j +: 8];
            for (int j = 0; j < 8; j++) b_pmem_rdata[8*j +: 8] = bmemB[a + j];
            logB.push_back('{b_pmem_write, b_pmem_address, b_pmem_wdata, b_pmem_byte_enable});
            b_pmem_resp = 1'b1;
         end else begin
            b_pmem_resp = 1'b0;
         end
      end
   end

   task automatic model_write(input logic [31:0] base, input logic [255:0] wd, input logic [31:0] be);
      for (int j = 0; j < 32; j++)
         if (be[j]) refm[int'(base[9:0]) + j] = wd[8*j +: 8];
   endtask

   function automatic logic [255:0] model_read(input logic [31:0] base);
      logic [255:0] r;
      for (int j = 0; j < 32; j++) r[8*j +: 8] = refm[int'(base[9:0]) + j];
      return r;
   endfunction

   // One cache transaction on the 256/32 instance with protocol checks
   task automatic txnA(input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [255:0] wd, input logic [31:0] be, input bit keep_rd,
                       output logic [255:0] got, output int lat);
      int n, c0;
      logic [31:0] base;
      base = addr & ~32'h1F;
      @(negedge clk);
      ca_write = wr; ca_read = rd; ca_address = addr; ca_wdata = wd; ca_byte_enable = be;
      logA.delete();
      c0 = cyc;
      n = 0;
      while (!ca_resp && n < 400) begin
         @(negedge clk);
         n++;
         if (n == 1) chk("first_beat_latency", {pmem_write, pmem_read}, wr ? 2'b10 : 2'b01);
         if (n == 2) begin
            ca_address = $urandom;
            ca_byte_enable = $urandom;
            for (int k = 0; k < 8; k++) ca_wdata[32*k +: 32] = $urandom;
         end
      end
      chk("resp_timeout", n < 400, 1'b1);
      got = ca_rdata;
      lat = cyc - c0;
      chk("burst_low_in_resp", {pmem_read, pmem_write}, 2'b00);
      chk("resp_after_last_strobe", cyc - last_strobeA, 1);
      ca_write = 1'b0;
      ca_address = addr;
      if (!keep_rd) ca_read = 1'b0;
      chk("beat_count", logA.size(), NB);
      foreach (logA[i]) begin
         chk("beat_addr", logA[i].addr, base + 32'(4 * i));
         chk("beat_dir", logA[i].wr, wr);
         if (wr) begin
            chk("beat_wdata", logA[i].data, wd[32*i +: 32]);
            chk("beat_be", logA[i].be, be[4*i +: 4]);
         end
      end
      @(negedge clk);
      chk("resp_one_cycle", ca_resp, 1'b0);
   endtask

   task automatic doA(input logic wr, input logic [31:0] addr, input logic [255:0] wd,
                      input logic [31:0] be, output logic [255:0] got);
      int lat;
      logic [31:0] base;
      base = addr & ~32'h1F;
      txnA(wr, !wr, addr, wd, be, 1'b0, got, lat);
      if (wr) begin
         model_write(base, wd, be);
         chk("rdata_held", got, last_rd);
      end else begin
         chk("rdata_model", got, model_read(base));
         last_rd = got;
      end
      if (per == 1 && !rnd_resp) chk("latency", lat, NB + 1);
   endtask

   task automatic txnB(input logic wr, input logic [31:0] addr, input logic [511:0] wd,
                       input logic [63:0] be);
      int n;
      logic [31:0] base;
      logic [511:0] exp;
      base = addr & ~32'h3F;
      @(negedge clk);
      b_ca_write = wr; b_ca_read = !wr; b_ca_address = addr; b_ca_wdata = wd; b_ca_byte_enable = be;
      logB.delete();
      n = 0;
      while (!b_ca_resp && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("b_resp_timeout", n < 400, 1'b1);
      b_ca_write = 1'b0;
      b_ca_read = 1'b0;
      chk("b_beat_count", logB.size(), 8);
      foreach (logB[i]) begin
         chk("b_beat_addr", logB[i].addr, base + 32'(8 * i));
         if (wr) begin
            chk("b_beat_wdata", logB[i].data, wd[64*i +: 64]);
            chk("b_beat_be", logB[i].be, be[8*i +: 8]);
         end
      end
      if (wr) begin
         for (int j = 0; j < 64; j++)
            if (be[j]) refB[int'(base[9:0]) + j] = wd[8*j +: 8];
      end else begin
         for (int j = 0; j < 64; j++) exp[8*j +: 8] = refB[int'(base[9:0]) + j];
         chk("b_rdata", b_ca_rdata, exp);
      end
      @(negedge clk);
   endtask

   typedef struct {
      logic         wr;
      logic [31:0]  addr;
      logic [255:0] wd;
      logic [31:0]  be;
      logic [255:0] exp;
   } vec_t;
   vec_t tbl[5];

   initial begin
      logic [255:0] got, wd;
      logic [511:0] wdb;
      logic [31:0]  addr;
      int n, s0, lat;

      tbl[0] = '{1'b0, 32'h100, '0, '0,
                 256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111};
      tbl[1] = '{1'b1, 32'h200, {32{8'hA5}}, 32'hFFFF_FFFE, '0};
      tbl[2] = '{1'b0, 32'h21F, '0, '0, {{31{8'hA5}}, 8'h00}};
      tbl[3] = '{1'b1, 32'h300, {8{32'hDEADBEEF}}, 32'h0000_FFFF, '0};
      tbl[4] = '{1'b0, 32'h300, '0, '0, {128'h0, {4{32'hDEADBEEF}}}};

      for (int i = 0; i < 1024; i++) begin
         bmem[i] = 8'h00; refm[i] = 8'h00; bmemB[i] = 8'h00; refB[i] = 8'h00;
      end
      for (int k = 0; k < 8; k++)
         for (int j = 0; j < 4; j++) begin
            bmem[32'h100 + 4*k + j] = 8'(8'h11 * (k + 1));
            refm[32'h100 + 4*k + j] = 8'(8'h11 * (k + 1));
         end

      ca_read = 0; ca_write = 0; ca_address = '0; ca_wdata = '0; ca_byte_enable = '0;
      b_ca_read = 0; b_ca_write = 0; b_ca_address = '0; b_ca_wdata = '0; b_ca_byte_enable = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ca_rdata", ca_rdata, '0);
      chk("rst_ca_resp", ca_resp, 1'b0);
      chk("rst_pmem_rw", {pmem_read, pmem_write}, 2'b00);
      chk("rst_pmem_addr", pmem_address, '0);
      chk("rst_pmem_wdata", {pmem_wdata, pmem_byte_enable}, '0);
      chk("rst_b_outputs", {b_ca_resp, b_pmem_read, b_pmem_write, b_pmem_address,
                            b_pmem_wdata, b_pmem_byte_enable}, '0);
      chk("rst_b_rdata", b_ca_rdata, '0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Directed vectors
      for (int i = 0; i < 5; i++) begin
         doA(tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].be, got);
         if (!tbl[i].wr) chk("tbl_rdata", got, tbl[i].exp);
      end

      // Reset in the middle of a read burst
      @(negedge clk);
      ca_read = 1'b1; ca_address = 32'h100;
      s0 = strobesA;
      n = 0;
      while (strobesA - s0 < 3 && n < 100) begin
         @(posedge clk);
         n++;
      end
      chk("abort_reached_beat3", strobesA - s0, 3);
      #2;
      rst = 1'b0;
      ca_read = 1'b0;
      #1;
      chk("abort_ca_rdata", ca_rdata, '0);
      chk("abort_outputs", {ca_resp, pmem_read, pmem_write, pmem_address}, '0);
      @(negedge clk);
      chk("abort_no_resp", ca_resp, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_idle_after", {ca_resp, pmem_read, pmem_write}, 3'b000);
      last_rd = '0;
      doA(1'b0, 32'h100, '0, '0, got);
      doA(1'b0, 32'h200, '0, '0, got);

      // Stalled bursts: one strobe every third cycle
      per = 3;
      for (int k = 0; k < 8; k++) wd[32*k +: 32] = $urandom;
      doA(1'b1, 32'h340, wd, 32'hFFFF_FFFF, got);
      doA(1'b0, 32'h340, '0, '0, got);
      per = 1;

      // Read and write together: write first, then the held read
      for (int k = 0; k < 8; k++) wd[32*k +: 32] = $urandom;
      txnA(1'b1, 1'b1, 32'h380, wd, 32'hFFFF_FFFF, 1'b1, got, lat);
      model_write(32'h380, wd, 32'hFFFF_FFFF);
      chk("prio_idle_gap", pmem_read, 1'b0);
      logA.delete();
      @(negedge clk);
      chk("prio_read_start", pmem_read, 1'b1);
      n = 0;
      while (!ca_resp && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("prio_resp_timeout", n < 400, 1'b1);
      chk("prio_rdata", ca_rdata, model_read(32'h380));
      chk("prio_beats", logA.size(), NB);
      ca_read = 1'b0;
      last_rd = ca_rdata;
      @(negedge clk);

      // Randomised transactions against the reference memory
      for (int t = 0; t < 24; t++) begin
         per = $urandom_range(1, 3);
         rnd_resp = ($urandom_range(0, 3) == 0);
         addr = $urandom_range(0, 1023);
         for (int k = 0; k < 8; k++) wd[32*k +: 32] = $urandom;
         doA(1'($urandom_range(0, 1)), addr, wd, $urandom, got);
      end
      per = 1;
      rnd_resp = 1'b0;

      // 512/64 instance: full and partial round-trips
      for (int k = 0; k < 16; k++) wdb[32*k +: 32] = $urandom;
      txnB(1'b1, 32'h80, wdb, '1);
      txnB(1'b0, 32'h80, '0, '0);
      for (int k = 0; k < 16; k++) wdb[32*k +: 32] = $urandom;
      txnB(1'b1, 32'h107, wdb, {$urandom, $urandom});
      txnB(1'b0, 32'h100, '0, '0);
      txnB(1'b0, 32'h0, '0, '0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
